// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar ping scheduler.
package sonar_pkg;

  localparam int DEF_ANGLE_WIDTH     = 7;
  localparam int DEF_TIME_WIDTH      = 24;
  localparam int DEF_ANGLE_MIN       = -30;
  localparam int DEF_ANGLE_MAX       = 30;
  localparam int DEF_ANGLE_STEP      = 5;
  localparam int DEF_SETTLE_CYCLES   = 4;
  localparam int DEF_BURST_CYCLES    = 524288;
  localparam int DEF_LISTEN_CYCLES   = 4194304;
  localparam int DEF_COOLDOWN_CYCLES = 65536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_BURST,
    ST_LISTEN,
    ST_REPORT,
    ST_COOLDOWN
  } scan_state_t;

  // One ping's result record at the default widths.
  typedef struct packed {
    logic signed [DEF_ANGLE_WIDTH-1:0] angle;
    logic [DEF_TIME_WIDTH-1:0]         tof;
    logic                              hit;
  } scan_result_t;

endpackage

// File: rtl/sonar_scan_sequencer_cycle_timer.sv
// Loadable down-counter; done_out is high while the count sits at zero.
// Loading N-1 on entry to a phase makes done_out rise on its N-th cycle.
module cycle_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic             done_out
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = load_val_in;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_out = (count_q == '0);

endmodule

// File: rtl/sonar_scan_sequencer.sv
// Sonar ping scheduler: settle / burst / listen / report / cooldown per ping,
// bouncing beam sweep, first-echo timestamp and valid/ready result record.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable_in
// SETTLE   | rx pipeline flush after angle change, rx_clear_out high
// BURST    | transmitter driven, echoes blanked, emission counter runs
// LISTEN   | echo window, first echo latches the emission counter
// REPORT   | result record held valid until the consumer accepts it
// COOLDOWN | dead time before the next ping's SETTLE
module sonar_scan_sequencer
  import sonar_pkg::*;
#(
  parameter int ANGLE_WIDTH     = DEF_ANGLE_WIDTH,
  parameter int TIME_WIDTH      = DEF_TIME_WIDTH,
  parameter int ANGLE_MIN       = DEF_ANGLE_MIN,
  parameter int ANGLE_MAX       = DEF_ANGLE_MAX,
  parameter int ANGLE_STEP      = DEF_ANGLE_STEP,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int BURST_CYCLES    = DEF_BURST_CYCLES,
  parameter int LISTEN_CYCLES   = DEF_LISTEN_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic                          echo_detected_in,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          tx_enable_out,
  output logic                          burst_start_out,
  output logic                          rx_clear_out,
  output logic                          listen_out,
  output logic [TIME_WIDTH-1:0]         time_since_emission_out,
  output logic                          result_valid_out,
  input  logic                          result_ready_in,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic [TIME_WIDTH-1:0]         result_time_out,
  output logic                          result_hit_out,
  output logic                          sweep_done_out
);

  localparam int AXW = ANGLE_WIDTH + 1;

  localparam logic [TIME_WIDTH-1:0] SETTLE_LD   = TIME_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] BURST_LD    = TIME_WIDTH'(BURST_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] LISTEN_LD   = TIME_WIDTH'(LISTEN_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] COOLDOWN_LD = TIME_WIDTH'(COOLDOWN_CYCLES - 1);

  localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_RST = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [AXW-1:0]         MIN_X     = AXW'(ANGLE_MIN);
  localparam logic signed [AXW-1:0]         MAX_X     = AXW'(ANGLE_MAX);
  localparam logic signed [AXW-1:0]         STEP_X    = AXW'(ANGLE_STEP);

  scan_state_t state_q, state_d;

  logic                          timer_load, timer_done;
  logic [TIME_WIDTH-1:0]         timer_val;
  logic [TIME_WIDTH-1:0]         time_q, time_d;
  logic                          hit_q, hit_d;
  logic [TIME_WIDTH-1:0]         tof_q, tof_d;
  logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                          dir_up_q, dir_up_d;
  logic                          res_valid_q, res_valid_d;
  logic signed [ANGLE_WIDTH-1:0] res_angle_q, res_angle_d;
  logic [TIME_WIDTH-1:0]         res_time_q, res_time_d;
  logic                          res_hit_q, res_hit_d;
  logic                          sweep_done_q, sweep_done_d;

  logic                          handshake, emit_now, emit_next;
  logic signed [AXW-1:0]         ang_x, up_x, dn_x, next_x;
  logic                          reverse;

  cycle_timer #(.WIDTH(TIME_WIDTH)) u_timer (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .load_in    (timer_load),
    .load_val_in(timer_val),
    .done_out   (timer_done)
  );

  assign handshake = (state_q == ST_REPORT) && res_valid_q && result_ready_in;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the phase timer is loaded on every transition into a timed phase.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      ST_IDLE: if (enable_in) begin
        state_d = ST_SETTLE; timer_load = 1'b1; timer_val = SETTLE_LD;
      end
      ST_SETTLE: if (timer_done) begin
        state_d = ST_BURST; timer_load = 1'b1; timer_val = BURST_LD;
      end
      ST_BURST: if (timer_done) begin
        state_d = ST_LISTEN; timer_load = 1'b1; timer_val = LISTEN_LD;
      end
      ST_LISTEN: if (timer_done) begin
        state_d = ST_REPORT;
      end
      ST_REPORT: if (handshake) begin
        if (enable_in) begin
          state_d = ST_COOLDOWN; timer_load = 1'b1; timer_val = COOLDOWN_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOLDOWN: if (timer_done) begin
        state_d = ST_SETTLE; timer_load = 1'b1; timer_val = SETTLE_LD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase strobes decoded from the registered state and emission counter.
  always_comb begin
    tx_enable_out   = 1'b0;
    burst_start_out = 1'b0;
    rx_clear_out    = 1'b0;
    listen_out      = 1'b0;
    unique case (state_q)
      ST_SETTLE: rx_clear_out = 1'b1;
      ST_BURST: begin
        tx_enable_out   = 1'b1;
        burst_start_out = (time_q == '0);
      end
      ST_LISTEN: listen_out = 1'b1;
      default: ;
    endcase
  end

  // Emission counter, echo latch, result record and sweep stepping.
  always_comb begin
    emit_now  = (state_q == ST_BURST) || (state_q == ST_LISTEN);
    emit_next = (state_d == ST_BURST) || (state_d == ST_LISTEN);
    time_d    = '0;
    if (emit_now && emit_next) begin
      time_d = (time_q == '1) ? time_q : time_q + 1'b1;
    end

    hit_d = hit_q;
    tof_d = tof_q;
    if (state_q == ST_SETTLE) begin
      hit_d = 1'b0;
      tof_d = '0;
    end else if ((state_q == ST_LISTEN) && echo_detected_in && !hit_q) begin
      hit_d = 1'b1;
      tof_d = time_q;
    end

    ang_x  = {angle_q[ANGLE_WIDTH-1], angle_q};
    up_x   = ang_x + STEP_X;
    dn_x   = ang_x - STEP_X;
    next_x = dir_up_q ? up_x : dn_x;
    reverse = 1'b0;
    if (dir_up_q && (up_x > MAX_X)) begin
      next_x = dn_x; reverse = 1'b1;
    end else if (!dir_up_q && (dn_x < MIN_X)) begin
      next_x = up_x; reverse = 1'b1;
    end

    angle_d      = angle_q;
    dir_up_d     = dir_up_q;
    res_valid_d  = res_valid_q;
    res_angle_d  = res_angle_q;
    res_time_d   = res_time_q;
    res_hit_d    = res_hit_q;
    sweep_done_d = 1'b0;

    // Capture uses hit_d/tof_d so an echo on the last listen cycle still counts.
    if ((state_q == ST_LISTEN) && (state_d == ST_REPORT)) begin
      res_valid_d = 1'b1;
      res_angle_d = angle_q;
      res_time_d  = tof_d;
      res_hit_d   = hit_d;
    end else if (handshake) begin
      res_valid_d  = 1'b0;
      res_angle_d  = '0;
      res_time_d   = '0;
      res_hit_d    = 1'b0;
      angle_d      = next_x[ANGLE_WIDTH-1:0];
      dir_up_d     = reverse ? !dir_up_q : dir_up_q;
      sweep_done_d = reverse;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      time_q       <= '0;
      hit_q        <= 1'b0;
      tof_q        <= '0;
      angle_q      <= ANGLE_RST;
      dir_up_q     <= 1'b1;
      res_valid_q  <= 1'b0;
      res_angle_q  <= '0;
      res_time_q   <= '0;
      res_hit_q    <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      time_q       <= time_d;
      hit_q        <= hit_d;
      tof_q        <= tof_d;
      angle_q      <= angle_d;
      dir_up_q     <= dir_up_d;
      res_valid_q  <= res_valid_d;
      res_angle_q  <= res_angle_d;
      res_time_q   <= res_time_d;
      res_hit_q    <= res_hit_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign beam_angle_out          = angle_q;
  assign time_since_emission_out = time_q;
  assign result_valid_out        = res_valid_q;
  assign result_angle_out        = res_angle_q;
  assign result_time_out         = res_time_q;
  assign result_hit_out          = res_hit_q;
  assign sweep_done_out          = sweep_done_q;

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// Bench for sonar_scan_sequencer: timeline model of each ping plus
// directed scenarios and a randomized soak.
module tb_sonar_scan_sequencer;

  localparam int AW     = 7;
  localparam int TW     = 24;
  localparam int AMIN   = -10;
  localparam int AMAX   = 10;
  localparam int ASTEP  = 10;
  localparam int S      = 2;
  localparam int B      = 8;
  localparam int L      = 32;
  localparam int C      = 4;
  localparam int LSTART = S + B;
  localparam int PEND   = S + B + L;
  localparam int NSTEPS = (AMAX - AMIN) / ASTEP;

  logic clk_in = 1'b0;
  logic rst_n = 1'b1;
  logic enable_in = 1'b0;
  logic echo_detected_in = 1'b0;
  logic result_ready_in = 1'b0;

  logic signed [AW-1:0] beam_angle_out;
  logic                 tx_enable_out, burst_start_out, rx_clear_out, listen_out;
  logic [TW-1:0]        time_since_emission_out;
  logic                 result_valid_out;
  logic signed [AW-1:0] result_angle_out;
  logic [TW-1:0]        result_time_out;
  logic                 result_hit_out, sweep_done_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int sweep_cnt = 0;

  sonar_scan_sequencer #(
    .ANGLE_WIDTH(AW), .TIME_WIDTH(TW), .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX),
    .ANGLE_STEP(ASTEP), .SETTLE_CYCLES(S), .BURST_CYCLES(B),
    .LISTEN_CYCLES(L), .COOLDOWN_CYCLES(C)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable_in(enable_in),
    .echo_detected_in(echo_detected_in), .beam_angle_out(beam_angle_out),
    .tx_enable_out(tx_enable_out), .burst_start_out(burst_start_out),
    .rx_clear_out(rx_clear_out), .listen_out(listen_out),
    .time_since_emission_out(time_since_emission_out),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_angle_out(result_angle_out), .result_time_out(result_time_out),
    .result_hit_out(result_hit_out), .sweep_done_out(sweep_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Sweep position k maps onto a triangle wave of period 2*NSTEPS.
  function automatic int angle_of(int k);
    int p;
    p = k % (2 * NSTEPS);
    return AMIN + ASTEP * ((p <= NSTEPS) ? p : 2 * NSTEPS - p);
  endfunction

  function automatic bit reverses_after(int k);
    int p;
    p = k % (2 * NSTEPS);
    return (p == NSTEPS) || (p == 0 && k > 0);
  endfunction

  function automatic bit in_rng(int v, int lo, int hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Model: m_t is the cycle offset within the ping timeline
  // (negative = cooldown, 0..S-1 settle, then burst, listen, report from PEND).
  bit m_busy, m_hit, m_sweep;
  int m_t, m_k, m_tof;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_t <= 0; m_k <= 0; m_hit <= 1'b0; m_tof <= 0; m_sweep <= 1'b0;
    end else begin
      m_sweep <= 1'b0;
      if (!m_busy) begin
        if (enable_in) begin m_busy <= 1'b1; m_t <= 0; end
      end else if (m_t >= PEND) begin
        if (result_ready_in) begin
          m_sweep <= reverses_after(m_k);
          m_k     <= m_k + 1;
          m_hit   <= 1'b0;
          m_tof   <= 0;
          if (enable_in) m_t <= -C;
          else m_busy <= 1'b0;
        end
      end else begin
        if (in_rng(m_t, LSTART, PEND) && echo_detected_in && !m_hit) begin
          m_hit <= 1'b1;
          m_tof <= m_t - S;
        end
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("beam_angle", $signed(beam_angle_out), angle_of(m_k));
      chk("tx_enable", tx_enable_out, m_busy && in_rng(m_t, S, LSTART));
      chk("burst_start", burst_start_out, m_busy && (m_t == S));
      chk("rx_clear", rx_clear_out, m_busy && in_rng(m_t, 0, S));
      chk("listen", listen_out, m_busy && in_rng(m_t, LSTART, PEND));
      chk("time_since", time_since_emission_out,
          (m_busy && in_rng(m_t, S, PEND)) ? m_t - S : 0);
      chk("result_valid", result_valid_out, m_busy && (m_t >= PEND));
      chk("result_angle", $signed(result_angle_out),
          (m_busy && (m_t >= PEND)) ? angle_of(m_k) : 0);
      chk("result_time", result_time_out, (m_busy && (m_t >= PEND)) ? m_tof : 0);
      chk("result_hit", result_hit_out, m_busy && (m_t >= PEND) && m_hit);
      chk("sweep_done", sweep_done_out, m_sweep);
      if (sweep_done_out) sweep_cnt <= sweep_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit probe(int which);
    case (which)
      0: return result_valid_out;
      1: return tx_enable_out;
      2: return listen_out;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_probe(input int which, input string nm);
    int n;
    n = 0;
    while (!probe(which) && n < 400) begin tick(); n++; end
    if (!probe(which)) begin
      checks++; errors++;
      $display("FAIL %s timeout: signal low after %0d cycles, expected high", nm, n);
    end
  endtask

  task automatic wait_time(input int v, input string nm);
    int n;
    n = 0;
    while (time_since_emission_out != TW'(v) && n < 400) begin tick(); n++; end
    if (time_since_emission_out != TW'(v)) begin
      checks++; errors++;
      $display("FAIL %s timeout: counter %0d, expected %0d", nm, time_since_emission_out, v);
    end
  endtask

  int angles[6];
  int exp_angles[6] = '{-10, 0, 10, 0, -10, 0};

  initial begin
    int n, bad;
    logic signed [AW-1:0] h_ang;
    logic [TW-1:0]        h_time;
    logic                 h_hit;

    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_angle", $signed(beam_angle_out), -10);
    chk("reset_valid", result_valid_out, 0);

    // 1: plain ping, no echo
    result_ready_in = 1'b1;
    enable_in = 1'b1;
    n = 0;
    while (!burst_start_out && n < 20) begin tick(); n++; end
    chk("s1_burst_latency", n, 3);
    n = 0;
    while (tx_enable_out && n < 100) begin n++; tick(); end
    chk("s1_tx_cycles", n, 8);
    n = 0;
    while (listen_out && n < 100) begin n++; tick(); end
    chk("s1_listen_cycles", n, 32);
    chk("s1_valid", result_valid_out, 1);
    chk("s1_angle", $signed(result_angle_out), -10);
    chk("s1_time", result_time_out, 0);
    chk("s1_hit", result_hit_out, 0);
    angles[0] = int'($signed(result_angle_out));
    tick();

    // 2: echoes at counter 20 and 25, then a blanked echo at 5
    wait_time(20, "s2_wait20");
    echo_detected_in = 1'b1; tick(); echo_detected_in = 1'b0;
    wait_time(25, "s2_wait25");
    echo_detected_in = 1'b1; tick(); echo_detected_in = 1'b0;
    wait_probe(0, "s2_valid");
    chk("s2_time", result_time_out, 20);
    chk("s2_hit", result_hit_out, 1);
    angles[1] = int'($signed(result_angle_out));
    tick();
    wait_time(5, "s2_wait5");
    echo_detected_in = 1'b1; tick(); echo_detected_in = 1'b0;
    wait_probe(0, "s2b_valid");
    chk("s2b_hit", result_hit_out, 0);
    chk("s2b_time", result_time_out, 0);
    angles[2] = int'($signed(result_angle_out));
    tick();

    // 3: more pings of the sweep
    for (int i = 3; i < 5; i++) begin
      wait_probe(0, "s3_valid");
      angles[i] = int'($signed(result_angle_out));
      tick();
    end

    // 4: consumer stalls for 50 cycles
    result_ready_in = 1'b0;
    wait_probe(0, "s4_valid");
    angles[5] = int'($signed(result_angle_out));
    h_ang = result_angle_out; h_time = result_time_out; h_hit = result_hit_out;
    bad = 0;
    repeat (50) begin
      tick();
      if (!result_valid_out || result_angle_out != h_ang || result_time_out != h_time ||
          result_hit_out != h_hit || tx_enable_out || rx_clear_out) bad++;
    end
    chk("s4_hold_violations", bad, 0);
    result_ready_in = 1'b1;
    tick();
    chk("s4_valid_dropped", result_valid_out, 0);
    n = 0;
    while (!rx_clear_out && n < 50) begin n++; tick(); end
    chk("s4_cooldown_cycles", n, 4);
    for (int i = 0; i < 6; i++) chk("s3_angle_seq", angles[i], exp_angles[i]);
    chk("s3_sweep_pulses", sweep_cnt, 2);

    // 5: enable dropped mid-listen
    wait_probe(2, "s5_listen");
    enable_in = 1'b0;
    repeat (5) tick();
    wait_probe(0, "s5_valid");
    chk("s5_angle", $signed(result_angle_out), 10);
    tick();
    bad = 0;
    repeat (10) begin
      tick();
      if (tx_enable_out || rx_clear_out || listen_out || result_valid_out ||
          time_since_emission_out != '0) bad++;
    end
    chk("s5_idle_activity", bad, 0);
    chk("s5_angle_advanced", $signed(beam_angle_out), 0);

    // 6: reset in the middle of a burst
    enable_in = 1'b1;
    wait_probe(1, "s6_tx");
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("s6_tx_async_drop", tx_enable_out, 0);
    chk("s6_angle", $signed(beam_angle_out), -10);
    chk("s6_valid", result_valid_out, 0);
    tick(); tick();
    rst_n = 1'b1;

    // randomized soak with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      enable_in        = ($urandom_range(0, 9) != 0);
      result_ready_in  = ($urandom_range(0, 2) != 0);
      echo_detected_in = ($urandom_range(0, 7) == 0);
      if (i == 1500) begin
        #($urandom_range(1, 7)) rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
